// File: rtl/muldiv_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : muldiv_sequencer_if                                    |
// | Description : Execute/Decode-side bundle for the HI/LO mult/div unit |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
interface muldiv_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             startE;
  logic [1:0]       opE;
  logic [WIDTH-1:0] srcaE;
  logic [WIDTH-1:0] srcbE;
  logic             hienE;
  logic             loenE;
  logic [WIDTH-1:0] wdE;
  logic             hazardD;
  logic             stallD;
  logic             busy;
  logic             done;
  logic             divz;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  // Pipeline side: issues operations, observes results and stall.
  modport master (
    output startE, opE, srcaE, srcbE, hienE, loenE, wdE, hazardD,
    input  stallD, busy, done, divz, hi, lo
  );

  // Unit side: consumes operations, owns HI/LO.
  modport slave (
    input  startE, opE, srcaE, srcbE, hienE, loenE, wdE, hazardD,
    output stallD, busy, done, divz, hi, lo
  );
endinterface
`default_nettype wire

// File: rtl/muldiv_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : muldiv_sequencer                                       |
// | Description : Iterative radix-2 multiply / restoring divide with     |
// |               HI/LO ownership, MTHI/MTLO writes and Decode stall.    |
// |               Optional macro MULDIV_EARLY_OUT_EN ends a multiply as  |
// |               soon as the remaining multiplier bits are all zero.    |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input wire clk,
  input wire reset,
  muldiv_sequencer_if.slave bus
);

  localparam int c_CNT_W = $clog2(WIDTH);
  localparam logic [c_CNT_W-1:0] c_LAST    = c_CNT_W'(WIDTH - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_stateNext;
  logic [c_CNT_W-1:0]   r_cnt;
  logic                 r_isDiv;
  logic                 r_negRes;   // operand signs differ on a signed op
  logic                 r_negRem;   // signed divide with negative dividend
  logic                 r_divZero;
  logic [WIDTH-1:0]     r_srcaRaw;
  logic [WIDTH-1:0]     r_opB;      // |multiplicand| or |divisor|
  logic [WIDTH-1:0]     r_opA;      // multiplier/product-low or dividend/quotient
  logic [WIDTH:0]       r_acc;      // product-high or remainder, one guard bit
  logic [WIDTH-1:0]     r_hi;
  logic [WIDTH-1:0]     r_lo;
  logic                 r_done;
  logic                 r_divz;

  logic                 w_busy;
  logic                 w_signedIn;
  logic [WIDTH-1:0]     w_absA;
  logic [WIDTH-1:0]     w_absB;
  logic [WIDTH:0]       w_mulSum;
  logic [WIDTH:0]       w_divShift;
  logic [WIDTH:0]       w_divTrial;
  logic                 w_divOk;
  logic                 w_lastIter;
  logic [2*WIDTH-1:0]   w_prod;
  logic [2*WIDTH-1:0]   w_prodAligned;
  logic [2*WIDTH-1:0]   w_prodFinal;
  logic [WIDTH-1:0]     w_quot;
  logic [WIDTH-1:0]     w_rem;
  logic [2*WIDTH-1:0]   w_result;

  // Operand conditioning at issue: magnitudes for signed ops.
  assign w_signedIn = bus.opE[0];
  assign w_absA = (w_signedIn && bus.srcaE[WIDTH-1]) ? -bus.srcaE : bus.srcaE;
  assign w_absB = (w_signedIn && bus.srcbE[WIDTH-1]) ? -bus.srcbE : bus.srcbE;

  // One shift-add step: acc has a spare top bit so the carry is kept.
  assign w_mulSum = r_opA[0] ? (r_acc + {1'b0, r_opB}) : r_acc;

  // One restoring-divide step on the WIDTH+1 bit partial remainder.
  assign w_divShift = {r_acc[WIDTH-1:0], r_opA[WIDTH-1]};
  assign w_divTrial = w_divShift - {1'b0, r_opB};
  assign w_divOk    = ~w_divTrial[WIDTH];

  assign w_prod = {r_acc[WIDTH-1:0], r_opA};

`ifdef MULDIV_EARLY_OUT_EN
  logic [WIDTH-1:0] r_mrem;   // untouched copy of the multiplier, shifted each step
  logic [WIDTH-1:0] w_mremShift;
  assign w_mremShift = r_mrem >> 1;
  assign w_lastIter  = (r_cnt == c_LAST) || (!r_isDiv && (w_mremShift == '0));
  // Skipped iterations would only have shifted the pair right; do that in one go.
  assign w_prodAligned = w_prod >> (c_LAST - r_cnt);
`else
  assign w_lastIter    = (r_cnt == c_LAST);
  assign w_prodAligned = w_prod;
`endif

  assign w_prodFinal = r_negRes ? -w_prodAligned : w_prodAligned;
  assign w_quot      = r_negRes ? -r_opA : r_opA;
  assign w_rem       = r_negRem ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];

  // Final HI:LO value selected during FIX.
  always_comb begin
    w_result = '0;
    if (!r_isDiv) begin
      w_result = w_prodFinal;
    end else if (r_divZero) begin
      w_result = {r_srcaRaw, {WIDTH{1'b1}}};
    end else begin
      w_result = {w_rem, w_quot};
    end
  end

  // Next-state logic for IDLE -> RUN -> FIX -> IDLE.
  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      S_IDLE:  if (bus.startE) w_stateNext = S_RUN;
      S_RUN:   if (w_lastIter) w_stateNext = S_FIX;
      S_FIX:   w_stateNext = S_IDLE;
      default: w_stateNext = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_stateNext;
  end

  // Datapath, HI/LO and status registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt     <= '0;
      r_isDiv   <= 1'b0;
      r_negRes  <= 1'b0;
      r_negRem  <= 1'b0;
      r_divZero <= 1'b0;
      r_srcaRaw <= '0;
      r_opB     <= '0;
      r_opA     <= '0;
      r_acc     <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_done    <= 1'b0;
      r_divz    <= 1'b0;
`ifdef MULDIV_EARLY_OUT_EN
      r_mrem    <= '0;
`endif
    end else begin
      r_done <= (r_state == S_FIX);
      case (r_state)
        S_IDLE: begin
          if (bus.startE) begin
            // Start wins over a same-cycle MTHI/MTLO.
            r_cnt     <= '0;
            r_isDiv   <= bus.opE[1];
            r_negRes  <= w_signedIn & (bus.srcaE[WIDTH-1] ^ bus.srcbE[WIDTH-1]);
            r_negRem  <= w_signedIn & bus.srcaE[WIDTH-1];
            r_divZero <= (bus.srcbE == '0);
            r_srcaRaw <= bus.srcaE;
            r_opA     <= bus.opE[1] ? w_absA : w_absB;
            r_opB     <= bus.opE[1] ? w_absB : w_absA;
            r_acc     <= '0;
            r_divz    <= 1'b0;
`ifdef MULDIV_EARLY_OUT_EN
            r_mrem    <= w_absB;
`endif
          end else begin
            if (bus.hienE) r_hi <= bus.wdE;
            if (bus.loenE) r_lo <= bus.wdE;
          end
        end
        S_RUN: begin
          // Counter parks at its last value instead of wrapping.
          if (!w_lastIter) r_cnt <= r_cnt + c_CNT_ONE;
          if (r_isDiv) begin
            r_acc <= w_divOk ? w_divTrial : w_divShift;
            r_opA <= {r_opA[WIDTH-2:0], w_divOk};
          end else begin
            r_acc <= {1'b0, w_mulSum[WIDTH:1]};
            r_opA <= {w_mulSum[0], r_opA[WIDTH-1:1]};
          end
`ifdef MULDIV_EARLY_OUT_EN
          r_mrem <= w_mremShift;
`endif
        end
        S_FIX: begin
          r_hi   <= w_result[2*WIDTH-1:WIDTH];
          r_lo   <= w_result[WIDTH-1:0];
          r_divz <= r_isDiv & r_divZero;
        end
        default: ;
      endcase
    end
  end

  assign w_busy     = (r_state == S_RUN) || (r_state == S_FIX);
  assign bus.busy   = w_busy;
  assign bus.stallD = w_busy & bus.hazardD;
  assign bus.done   = r_done;
  assign bus.divz   = r_divz;
  assign bus.hi     = r_hi;
  assign bus.lo     = r_lo;

endmodule
`default_nettype wire
